// File: rtl/moore_ser_pkg.sv
// Shared definitions for the pattern serializer: state encoding, default widths,
// the canonical detector pattern and the per-state output flags.
package moore_ser_pkg;

  localparam int STATE_W   = 3;
  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [3:0] PAT_1010 = 4'b1010;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'b000,
    SHIFT = 3'b001,
    LAST  = 3'b010,
    DONE  = 3'b011
  } ser_state_t;

  typedef struct packed {
    logic start_ready;
    logic busy;
    logic done;
    logic dout_valid;
  } ser_flags_t;

  // Output flags that hold while the FSM sits in state s
  function automatic ser_flags_t flags_for(ser_state_t s);
    ser_flags_t f;
    f = '{start_ready: 1'b1, busy: 1'b0, done: 1'b0, dout_valid: 1'b0};
    case (s)
      SHIFT, LAST: f = '{start_ready: 1'b0, busy: 1'b1, done: 1'b0, dout_valid: 1'b1};
      DONE:        f = '{start_ready: 1'b0, busy: 1'b1, done: 1'b1, dout_valid: 1'b0};
      default:     f = '{start_ready: 1'b1, busy: 1'b0, done: 1'b0, dout_valid: 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit position and repetition counter for the serializer; bit_idx walks
// MSB to LSB and wraps, taking one repetition off rep_cnt on each wrap.
module ser_bit_counter
  import moore_ser_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [CNT_W-1:0]         rep_load,
  input  logic                     step,
  output logic [$clog2(PAT_W)-1:0] bit_idx,
  output logic                     last_bit
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  logic [CNT_W-1:0] rep_cnt;

  // rep_cnt only counts down and holds at zero, so the maximum count cannot wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= '0;
      rep_cnt <= '0;
    end else if (load) begin
      bit_idx <= IDX_MAX;
      rep_cnt <= rep_load;
    end else if (step) begin
      if (bit_idx == '0) begin
        bit_idx <= IDX_MAX;
        if (rep_cnt != '0) rep_cnt <= rep_cnt - 1'b1;
      end else begin
        bit_idx <= bit_idx - 1'b1;
      end
    end
  end

  assign last_bit = (rep_cnt == CNT_W'(1)) && (bit_idx == IDX_W'(1));

endmodule

// File: rtl/moore_pattern_serializer.sv
// Moore transmitter: sends a latched pattern MSB-first, repeated back-to-back
// rep_in times, for the overlapping sequence detectors downstream.
module moore_pattern_serializer
  import moore_ser_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] rep_in,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);

  ser_state_t       state;
  ser_flags_t       flags;
  logic [PAT_W-1:0] pat_reg;
  logic [IDX_W-1:0] bit_idx;
  logic             last_bit;
  logic             accept;
  logic             step;

  assign accept = start_valid && start_ready && (state == IDLE);
  assign step   = (state == SHIFT);

  ser_bit_counter #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .rep_load (rep_in),
    .step     (step),
    .bit_idx  (bit_idx),
    .last_bit (last_bit)
  );

  // Flags are registered together with the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      flags   <= flags_for(IDLE);
      pat_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pat_reg <= pat_in;
            if (rep_in == '0) begin
              state <= DONE;
              flags <= flags_for(DONE);
            end else begin
              state <= SHIFT;
              flags <= flags_for(SHIFT);
            end
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state <= LAST;
            flags <= flags_for(LAST);
          end
        end
        LAST: begin
          state <= DONE;
          flags <= flags_for(DONE);
        end
        DONE: begin
          state <= IDLE;
          flags <= flags_for(IDLE);
        end
        default: begin
          state <= IDLE;
          flags <= flags_for(IDLE);
        end
      endcase
    end
  end

  assign start_ready = flags.start_ready;
  assign busy        = flags.busy;
  assign done        = flags.done;
  assign dout_valid  = flags.dout_valid;

  // dout depends only on registers, and is held low outside the data states
  assign dout = !flags.dout_valid ? 1'b0 :
                (state == LAST)   ? pat_reg[0] : pat_reg[bit_idx];

endmodule

// File: tb/tb_moore_pattern_serializer.sv
// Self-checking bench: a per-cycle queue model of the expected output stream,
// directed scenarios with literal expectations, and randomized traffic.
module tb_moore_pattern_serializer;
  import moore_ser_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] pat_in;
  logic [7:0] rep_in;
  logic       start_valid;
  logic       start_ready, dout, dout_valid, busy, done;

  logic [1:0] pat_b;
  logic [2:0] rep_b;
  logic       start_valid_b;
  logic       start_ready_b, dout_b, dout_valid_b, busy_b, done_b;

  moore_pattern_serializer #(.PAT_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .pat_in(pat_in), .rep_in(rep_in),
    .start_valid(start_valid), .start_ready(start_ready), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done)
  );

  moore_pattern_serializer #(.PAT_W(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .pat_in(pat_b), .rep_in(rep_b),
    .start_valid(start_valid_b), .start_ready(start_ready_b), .dout(dout_b),
    .dout_valid(dout_valid_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected per-cycle outputs {start_ready, busy, done, dout_valid, dout}
  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic valid;
    logic dout;
  } exp_t;

  localparam exp_t EXP_IDLE = 5'b10000;

  exp_t cur_exp = EXP_IDLE;
  exp_t exp_q[$];
  bit   model_live = 1'b0;

  // A job expands into PAT_W*rep data cycles followed by one done cycle
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      cur_exp    = EXP_IDLE;
      model_live = 1'b1;
    end else if (model_live) begin
      if (cur_exp.ready && start_valid) begin
        for (int r = 0; r < int'(rep_in); r++)
          for (int b = 3; b >= 0; b--)
            exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, pat_in[b]});
        exp_q.push_back(5'b01100);
      end
      cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : EXP_IDLE;
    end
  end

  always @(negedge clk) begin
    if (model_live)
      checkOutput("cycle", 32'({start_ready, busy, done, dout_valid, dout}), 32'(cur_exp));
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the done cycle
  task automatic applyStimulus(input logic [3:0] p, input logic [7:0] r, input int poke,
                               output logic [31:0] stream, output int nbits,
                               output int done_at);
    pat_in      = p;
    rep_in      = r;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    pat_in      = 4'($urandom);
    rep_in      = 8'($urandom);
    stream  = '0;
    nbits   = 0;
    done_at = 0;
    for (int k = 1; k <= 1100 && done_at == 0; k++) begin
      if (dout_valid) begin
        stream = {stream[30:0], dout};
        nbits++;
      end
      if (done) done_at = k;
      if (k == poke) begin
        start_valid = 1'b1;
        pat_in      = 4'b0001;
        rep_in      = 8'd1;
      end else begin
        start_valid = 1'b0;
      end
      if (done_at == 0) @(negedge clk);
    end
    start_valid = 1'b0;
    if (done_at == 0) checkOutput("job_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (!start_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!start_ready) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] s;
  int          n, d, hits, nb, db, alt_err;

  initial begin
    reset = 1'b1;
    start_valid = 1'b0; pat_in = '0; rep_in = '0;
    start_valid_b = 1'b0; pat_b = '0; rep_b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 32'({start_ready, busy, done, dout_valid, dout}), 32'b10000);
    checkOutput("reset_state_b", 32'({start_ready_b, busy_b, done_b, dout_valid_b, dout_b}), 32'b10000);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single repetition");
    applyStimulus(PAT_1010, 8'd1, 0, s, n, d);
    checkOutput("single_bits", 32'(n), 32'd4);
    checkOutput("single_stream", 32'(s[3:0]), 32'b1010);
    checkOutput("single_done_at", 32'(d), 32'd5);
    @(negedge clk);
    checkOutput("single_ready_back", 32'(start_ready), 32'd1);

    $display("[TB] overlapping stream");
    applyStimulus(PAT_1010, 8'd3, 0, s, n, d);
    hits = 0;
    for (int i = 0; i <= 8; i++) if (s[i+3 -: 4] == 4'b1010) hits++;
    checkOutput("overlap_bits", 32'(n), 32'd12);
    checkOutput("overlap_stream", 32'(s[11:0]), 32'b101010101010);
    checkOutput("overlap_hits", 32'(hits), 32'd5);
    checkOutput("overlap_done_at", 32'(d), 32'd13);
    @(negedge clk);

    $display("[TB] zero repeats");
    applyStimulus(4'b0110, 8'd0, 0, s, n, d);
    checkOutput("zero_bits", 32'(n), 32'd0);
    checkOutput("zero_done_at", 32'(d), 32'd1);
    checkOutput("zero_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("zero_busy_idle", 32'(busy), 32'd0);

    $display("[TB] busy rejection and back-to-back");
    applyStimulus(4'b1100, 8'd2, 2, s, n, d);
    checkOutput("reject_bits", 32'(n), 32'd8);
    checkOutput("reject_stream", 32'(s[7:0]), 32'b11001100);
    checkOutput("reject_done_at", 32'(d), 32'd9);
    pat_in = PAT_1010; rep_in = 8'd1; start_valid = 1'b1;
    @(negedge clk);
    checkOutput("b2b_idle_ready", 32'({start_ready, dout_valid}), 32'b10);
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput("b2b_first_bit", 32'({busy, dout_valid, dout}), 32'b111);
    waitIdle();

    $display("[TB] reset mid-stream");
    pat_in = 4'b1100; rep_in = 8'd2; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midreset_outputs", 32'({start_ready, busy, done, dout_valid, dout}), 32'b10000);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("midreset_no_done", 32'({done, dout_valid}), 32'b00);
    end
    applyStimulus(4'b0110, 8'd1, 0, s, n, d);
    checkOutput("fresh_stream", 32'(s[3:0]), 32'b0110);
    checkOutput("fresh_bits", 32'(n), 32'd4);
    @(negedge clk);

    $display("[TB] maximum repeat count");
    applyStimulus(4'b1001, 8'd255, 0, s, n, d);
    checkOutput("max_bits", 32'(n), 32'd1020);
    checkOutput("max_tail", 32'(s[7:0]), 32'b10011001);
    checkOutput("max_done_at", 32'(d), 32'd1021);
    @(negedge clk);

    $display("[TB] narrow instance maximum count");
    pat_b = 2'b10; rep_b = 3'd7; start_valid_b = 1'b1;
    @(negedge clk);
    start_valid_b = 1'b0;
    nb = 0; db = 0; alt_err = 0;
    for (int k = 1; k <= 40 && db == 0; k++) begin
      if (dout_valid_b) begin
        if (dout_b !== ((nb % 2) == 0)) alt_err++;
        nb++;
      end
      if (done_b) db = k;
      if (db == 0) @(negedge clk);
    end
    checkOutput("narrow_bits", 32'(nb), 32'd14);
    checkOutput("narrow_alternation", 32'(alt_err), 32'd0);
    checkOutput("narrow_done_at", 32'(db), 32'd15);
    @(negedge clk);
    checkOutput("narrow_idle", 32'({start_ready_b, busy_b}), 32'b10);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      reset       = ($urandom_range(0, 63) == 0);
      start_valid = ($urandom_range(0, 2) == 0);
      pat_in      = 4'($urandom);
      rep_in      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(5, 20))
                                                : 8'($urandom_range(0, 4));
      @(negedge clk);
    end
    reset = 1'b0;
    start_valid = 1'b0;
    repeat (100) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moore_pattern_serializer.md
Name: moore_pattern_serializer

Overview:
- Moore-style transmitter that generates the serial bit stream the team's overlapping sequence detectors consume.
- Accepts a parallel pattern word and a repeat count over a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock, repeating it back-to-back with no gap, so overlapping detection can be exercised.
- Sits upstream of moore_fsm_overlapping in test and stimulus paths; also usable as a generic pattern source.

Parameters:
- PAT_W, 4: pattern width in bits; must be at least 2.
- CNT_W, 8: repeat-count width; maximum repeats is 2^CNT_W - 1.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- pat_in, input, PAT_W: pattern to transmit, MSB sent first.
- rep_in, input, CNT_W: number of back-to-back pattern repetitions.
- start_valid, input, 1: request to start transmitting.
- start_ready, output, 1: high only in IDLE.
- dout, output, 1: serial data bit.
- dout_valid, output, 1: dout carries a pattern bit this cycle.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse at the end of a job.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- All outputs are registered or decoded from the state register only (Moore). No input-to-output combinational path.
- States (3-bit encoding, listed in a shared package):
  - IDLE=000
  - SHIFT=001
  - LAST=010, the final bit of the final repetition
  - DONE=011
  - Codes 100-111 are illegal; default branch returns to IDLE.
- Reset values: state=IDLE, start_ready=1, dout=0, dout_valid=0, busy=0, done=0. Internal pat_reg, bit_idx and rep_cnt are all cleared to 0.
- Accept: the handshake completes when start_valid && start_ready at a rising edge while in IDLE. That edge latches pat_reg=pat_in and rep_cnt=rep_in, and sets bit_idx=PAT_W-1.
- If rep_in == 0: go to DONE. No dout_valid is asserted. done pulses in the cycle after acceptance.
- If rep_in == 1 and PAT_W bits remain: enter SHIFT. The path to LAST follows the counter rules below.
- Latency: the first bit, pat_in[PAT_W-1], appears with dout_valid=1 in the cycle after acceptance.
- SHIFT:
  - Each cycle: dout = pat_reg[bit_idx], dout_valid=1.
  - When bit_idx == 0: wrap bit_idx to PAT_W-1 and decrement rep_cnt.
  - Otherwise: decrement bit_idx.
  - Transition to LAST when the next bit is the final bit, i.e. rep_cnt==1 and bit_idx==1.
- LAST: dout = pat_reg[0], dout_valid=1, then go to DONE.
- DONE: done=1, busy=1, dout_valid=0, dout=0. Next state is IDLE.
- Stream properties:
  - The stream is contiguous across repetitions: no idle cycle between the last bit of repetition k and the MSB of repetition k+1.
  - Total valid bits = PAT_W * rep_in.
- start_valid outside IDLE is ignored; start_ready=0 there. Inputs are not sampled after acceptance.
- Back-to-back jobs: start_valid held high re-accepts in the first IDLE cycle after DONE. The minimum gap between jobs is 2 cycles with dout_valid=0 (DONE, then IDLE).
- dout is forced to 0 whenever dout_valid=0.
- Reset mid-operation aborts the job. Outputs take their reset values at the next edge, no done pulse is produced, and the partial stream is discarded.
- rep_in at its maximum (all ones) must complete without counter overflow. rep_cnt only decrements and never wraps.

Decomposition:
- Package moore_ser_pkg holds:
  - the state localparams (IDLE, SHIFT, LAST, DONE) and the state width of 3;
  - default PAT_W and CNT_W;
  - the canonical pattern constant PAT_1010 = 4'b1010 shared with the detector benches.
- One sub-module is natural: ser_bit_counter. It holds bit_idx and rep_cnt with load, step, wrap and a last_bit flag.
- The FSM and output decode stay in the top module.

Test Plan:
- Single repetition: reset 2 cycles; pat_in=4'b1010, rep_in=1, start_valid=1 for one cycle -> dout_valid high for cycles 1-4 after acceptance with dout = 1,0,1,0; done=1 in cycle 5; start_ready returns to 1 in cycle 6.
- Overlapping stream: pat_in=4'b1010, rep_in=3, output fed into moore_fsm_overlapping -> 12 contiguous bits 101010101010; the detector asserts 5 times; done 13 cycles after acceptance.
- Zero repeats: rep_in=0 -> dout_valid never asserts; done pulses exactly 1 cycle after acceptance; busy high for 1 cycle.
- Busy rejection: pat_in=4'b1100, rep_in=2 accepted; start_valid with pat_in=4'b0001 during SHIFT -> ignored; the stream is exactly 11001100; then start_valid held high -> the second job is accepted in the first IDLE cycle.
- Reset mid-stream: assert reset at bit 3 of rep_in=2 -> the next cycle has all outputs at reset values, no done pulse; a fresh job afterwards transmits correctly.
- Max count: PAT_W=2, CNT_W=3, pat_in=2'b10, rep_in=7 -> 14 bits alternating 1,0; done at cycle 15; no counter wrap.
